// File: rtl/em_pkg.sv
// Shared codes, request bundle and helpers for the external-memory data-port arbiter.
package em_pkg;

    localparam int EM_MEM_SIZE = 600;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    localparam logic [2:0] EMC_NONE = 3'd0;
    localparam logic [2:0] EMC_BYTE = 3'd1;
    localparam logic [2:0] EMC_HALF = 3'd2;
    localparam logic [2:0] EMC_WORD = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } em_state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } em_req_t;

    // Zero-extend a little-endian load to the access width.
    function automatic logic [31:0] em_mask(input logic [31:0] d, input logic [1:0] size);
        logic [31:0] r;
        r = '0;
        case (size)
            SZ_BYTE: r = {24'd0, d[7:0]};
            SZ_HALF: r = {16'd0, d[15:0]};
            SZ_WORD: r = d;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/em_lane_gen.sv
// Byte-lane address/data/control generator with bounds and size checking.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module em_lane_gen
    import em_pkg::*;
#(
    parameter int MEM_SIZE = EM_MEM_SIZE
)
(
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [9:0]  addr,
    input  logic [31:0] wdata,
    output logic [39:0] address,
    output logic [7:0]  dw0,
    output logic [7:0]  dw1,
    output logic [7:0]  dw2,
    output logic [7:0]  dw3,
    output logic [2:0]  control,
    output logic        err
);

    localparam logic [10:0] LIMIT = 11'(MEM_SIZE);

    logic [10:0] nbytes;
    logic [10:0] last_end;
    logic [9:0]  a1, a2, a3;

    always_comb begin
        nbytes = 11'd4;
        a1     = addr + 10'd1;
        a2     = addr + 10'd2;
        a3     = addr + 10'd3;
        dw0    = wdata[7:0];
        dw1    = wdata[15:8];
        dw2    = wdata[23:16];
        dw3    = wdata[31:24];
        // Unused lanes repeat A0 so the memory's all-lanes-valid check passes near the top.
        case (size)
            SZ_BYTE: begin
                nbytes = 11'd1;
                a1 = addr; a2 = addr; a3 = addr;
                dw1 = '0; dw2 = '0; dw3 = '0;
            end
            SZ_HALF: begin
                nbytes = 11'd2;
                a2 = addr; a3 = addr;
                dw2 = '0; dw3 = '0;
            end
            SZ_WORD: ;
            default: begin
                a1 = addr; a2 = addr; a3 = addr;
                dw0 = '0; dw1 = '0; dw2 = '0; dw3 = '0;
            end
        endcase
        last_end = {1'b0, addr} + nbytes;
        err      = (last_end > LIMIT) || (size == SZ_RSVD);
        address  = {a3, a2, a1, addr};
        control  = (we && !err) ? ({1'b0, size} + 3'd1) : EMC_NONE;
    end

endmodule

// File: rtl/em_port_arbiter.sv
// Round-robin arbiter of two requesters onto the external memory data port.
// Latency: 3 cycles per access (IDLE grant, ACCESS, RESP ack); no back-to-back issue.
// Backpressure: req held until ack; the losing request waits for the next IDLE.
module em_port_arbiter
    import em_pkg::*;
#(
    parameter int MEM_SIZE = EM_MEM_SIZE
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    input  logic [9:0]  m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_size,
    input  logic [9:0]  m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic [2:0]  em_control,
    output logic [39:0] em_address,
    output logic [7:0]  em_dw0,
    output logic [7:0]  em_dw1,
    output logic [7:0]  em_dw2,
    output logic [7:0]  em_dw3,
    input  logic [31:0] em_read,
    output logic        busy
);

    em_state_t   state, state_nxt;
    logic        last_grant;
    logic        grant;
    logic        id;
    logic        we_q;
    logic        err_q;
    logic [1:0]  size_q;
    logic [31:0] rdata_q;
    em_req_t     sel;

    logic [39:0] lg_address;
    logic [7:0]  lg_dw0, lg_dw1, lg_dw2, lg_dw3;
    logic [2:0]  lg_control;
    logic        lg_err;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant = (m0_req && m1_req) ? ~last_grant : m1_req;
        sel   = grant ? em_req_t'{m1_we, m1_size, m1_addr, m1_wdata}
                      : em_req_t'{m0_we, m0_size, m0_addr, m0_wdata};
    end

    em_lane_gen #(.MEM_SIZE(MEM_SIZE)) u_lane_gen (
        .we      (sel.we),
        .size    (sel.size),
        .addr    (sel.addr),
        .wdata   (sel.wdata),
        .address (lg_address),
        .dw0     (lg_dw0),
        .dw1     (lg_dw1),
        .dw2     (lg_dw2),
        .dw3     (lg_dw3),
        .control (lg_control),
        .err     (lg_err)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (m0_req || m1_req) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= 1'b1;
            id         <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= SZ_BYTE;
            rdata_q    <= '0;
            em_control <= EMC_NONE;
            em_address <= '0;
            em_dw0     <= '0;
            em_dw1     <= '0;
            em_dw2     <= '0;
            em_dw3     <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
        end else begin
            em_control <= EMC_NONE;
            em_address <= '0;
            em_dw0     <= '0;
            em_dw1     <= '0;
            em_dw2     <= '0;
            em_dw3     <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
            case (state)
                ST_IDLE: if (m0_req || m1_req) begin
                    last_grant <= grant;
                    id         <= grant;
                    we_q       <= sel.we;
                    size_q     <= sel.size;
                    err_q      <= lg_err;
                    em_control <= lg_control;
                    em_address <= lg_address;
                    em_dw0     <= lg_dw0;
                    em_dw1     <= lg_dw1;
                    em_dw2     <= lg_dw2;
                    em_dw3     <= lg_dw3;
                end
                ST_ACCESS: begin
                    rdata_q <= (we_q || err_q) ? '0 : em_mask(em_read, size_q);
                    if (id) begin
                        m1_ack <= 1'b1;
                        m1_err <= err_q;
                    end else begin
                        m0_ack <= 1'b1;
                        m0_err <= err_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m0_rdata = m0_ack ? rdata_q : '0;
    assign m1_rdata = m1_ack ? rdata_q : '0;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_em_port_arbiter.sv
// Bench for em_port_arbiter: directed vector table, tie/reset sequences, randomized traffic vs byte-level model.
module tb_em_port_arbiter;

    localparam int MEM = 600;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [1:0]  m0_size, m1_size;
    logic [9:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [2:0]  em_control;
    logic [39:0] em_address;
    logic [7:0]  em_dw0, em_dw1, em_dw2, em_dw3;
    logic [31:0] em_read;
    logic        busy;

    always #5 clock = ~clock;

    em_port_arbiter #(.MEM_SIZE(MEM)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .em_control(em_control), .em_address(em_address),
        .em_dw0(em_dw0), .em_dw1(em_dw1), .em_dw2(em_dw2), .em_dw3(em_dw3),
        .em_read(em_read), .busy(busy)
    );

    // External memory model: combinational read, lane writes at the clock edge, suppressed by reset.
    logic [7:0] ram [0:1023];
    logic [9:0] la0, la1, la2, la3;
    bit         mem_init_done = 1'b0;
    assign la0 = em_address[9:0];
    assign la1 = em_address[19:10];
    assign la2 = em_address[29:20];
    assign la3 = em_address[39:30];

    always_comb begin
        em_read = '0;
        if (la0 < 10'd600 && la1 < 10'd600 && la2 < 10'd600 && la3 < 10'd600)
            em_read = {ram[la3], ram[la2], ram[la1], ram[la0]};
    end

    always @(posedge clock) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'(i) ^ 8'h5A;
            mem_init_done <= 1'b1;
        end else if (!reset) begin
            case (em_control)
                3'd1: ram[la0] <= em_dw0;
                3'd2: begin ram[la0] <= em_dw0; ram[la1] <= em_dw1; end
                3'd3: begin ram[la0] <= em_dw0; ram[la1] <= em_dw1; ram[la2] <= em_dw2; ram[la3] <= em_dw3; end
                default: ;
            endcase
        end
    end

    // Reference model: a flat byte array plus the last winner.
    logic [7:0] ref_mem [0:1023];
    bit         last_win;
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    function automatic int nbytes_of(input logic [1:0] s);
        case (s)
            2'd0: return 1;
            2'd1: return 2;
            2'd2: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit ref_err(input logic [9:0] a, input logic [1:0] s);
        return (s == 2'd3) || (int'(a) + nbytes_of(s) > MEM);
    endfunction

    function automatic logic [31:0] ref_load(input logic [9:0] a, input logic [1:0] s);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < nbytes_of(s); i++) r[8*i +: 8] = ref_mem[int'(a) + i];
        return r;
    endfunction

    task automatic ref_store(input logic [9:0] a, input logic [1:0] s, input logic [31:0] wd);
        for (int i = 0; i < nbytes_of(s); i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    endtask

    task automatic drive(input bit p, input bit req, input bit we, input logic [1:0] sz,
                         input logic [9:0] a, input logic [31:0] wd);
        if (!p) begin
            m0_req = req; m0_we = we; m0_size = sz; m0_addr = a; m0_wdata = wd;
        end else begin
            m1_req = req; m1_we = we; m1_size = sz; m1_addr = a; m1_wdata = wd;
        end
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [1:0]  size;
        logic [9:0]  addr;
        logic [31:0] wdata;
        bit          chk_lanes;
        logic [2:0]  exp_ctrl;
        logic [39:0] exp_addr;
        logic [31:0] exp_dw;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input bit p, input bit we, input logic [1:0] sz, input logic [9:0] a,
                                input logic [31:0] wd, input logic [2:0] ctrl, input bit err,
                                input logic [31:0] rd);
        vec_t v;
        v.port = p; v.we = we; v.size = sz; v.addr = a; v.wdata = wd;
        v.chk_lanes = 1'b0; v.exp_ctrl = ctrl; v.exp_addr = '0; v.exp_dw = '0;
        v.exp_err = err; v.exp_rdata = rd;
        return v;
    endfunction

    // One isolated access: request at cycle t, ACCESS at t+1, ack at t+2.
    task automatic do_txn(input vec_t v, input int idx);
        logic ack_w, ack_o, err_w;
        logic [31:0] rd_w;
        @(negedge clock);
        drive(v.port, 1'b1, v.we, v.size, v.addr, v.wdata);
        @(negedge clock);
        chk($sformatf("v%0d_busy", idx), busy, 1'b1);
        chk($sformatf("v%0d_ctrl", idx), em_control, v.exp_ctrl);
        if (v.chk_lanes) begin
            chk($sformatf("v%0d_lanes", idx), em_address, v.exp_addr);
            chk($sformatf("v%0d_dw", idx), {em_dw3, em_dw2, em_dw1, em_dw0}, v.exp_dw);
        end
        @(negedge clock);
        ack_w = v.port ? m1_ack : m0_ack;
        ack_o = v.port ? m0_ack : m1_ack;
        err_w = v.port ? m1_err : m0_err;
        rd_w  = v.port ? m1_rdata : m0_rdata;
        chk($sformatf("v%0d_ack", idx), {ack_o, ack_w}, 2'b01);
        chk($sformatf("v%0d_err", idx), err_w, v.exp_err);
        chk($sformatf("v%0d_rdata", idx), rd_w, v.exp_rdata);
        drive(v.port, 1'b0, 1'b0, 2'd0, 10'd0, 32'd0);
        last_win = v.port;
        if (v.we && !ref_err(v.addr, v.size)) ref_store(v.addr, v.size, v.wdata);
    endtask

    function automatic logic [9:0] rand_addr();
        case ($urandom_range(0, 3))
            0, 1:    return 10'($urandom_range(0, 599));
            2:       return 10'($urandom_range(585, 610));
            default: return 10'($urandom_range(0, 1023));
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t tbl [12];

    initial begin
        bit          pend [2];
        bit          r_we [2];
        logic [1:0]  r_sz [2];
        logic [9:0]  r_a [2];
        logic [31:0] r_wd [2];
        bit          winner, exp_w;
        int          cyc;
        vec_t        v;

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        tbl[0]  = mk(0, 1, 2'd2, 10'd400, 32'h0A0B0C0D, 3'd3, 0, 32'h0);
        tbl[0].chk_lanes = 1'b1;
        tbl[0].exp_addr  = {10'd403, 10'd402, 10'd401, 10'd400};
        tbl[0].exp_dw    = 32'h0A0B0C0D;
        tbl[1]  = mk(0, 0, 2'd2, 10'd400, 32'h0, 3'd0, 0, 32'h0A0B0C0D);
        tbl[2]  = mk(1, 1, 2'd1, 10'd10, 32'h0000BEEF, 3'd2, 0, 32'h0);
        tbl[2].chk_lanes = 1'b1;
        tbl[2].exp_addr  = {10'd10, 10'd10, 10'd11, 10'd10};
        tbl[2].exp_dw    = 32'h0000BEEF;
        tbl[3]  = mk(1, 0, 2'd0, 10'd11, 32'h0, 3'd0, 0, 32'h000000BE);
        tbl[4]  = mk(0, 0, 2'd0, 10'd599, 32'h0, 3'd0, 0, 32'h0000000D);
        tbl[5]  = mk(0, 0, 2'd1, 10'd599, 32'h0, 3'd0, 1, 32'h0);
        tbl[6]  = mk(1, 1, 2'd3, 10'd0, 32'hFFFFFFFF, 3'd0, 1, 32'h0);
        tbl[7]  = mk(1, 0, 2'd0, 10'd0, 32'h0, 3'd0, 0, 32'h0000005A);
        tbl[8]  = mk(0, 1, 2'd2, 10'd596, 32'h11223344, 3'd3, 0, 32'h0);
        tbl[9]  = mk(0, 0, 2'd2, 10'd597, 32'h0, 3'd0, 1, 32'h0);
        tbl[10] = mk(1, 0, 2'd2, 10'd596, 32'h0, 3'd0, 0, 32'h11223344);
        tbl[11] = mk(0, 1, 2'd0, 10'd1023, 32'h000000AA, 3'd0, 1, 32'h0);

        reset = 1'b1;
        drive(0, 0, 0, 2'd0, 10'd0, 32'd0);
        drive(1, 0, 0, 2'd0, 10'd0, 32'd0);
        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ctrl", em_control, 3'd0);
        chk("rst_addr", em_address, 40'd0);
        chk("rst_dw", {em_dw3, em_dw2, em_dw1, em_dw0}, 32'd0);
        chk("rst_ack_err", {m1_ack, m1_err, m0_ack, m0_err}, 4'd0);
        chk("rst_rdata", {m1_rdata, m0_rdata}, 40'd0);
        reset = 1'b0;
        last_win = 1'b1;

        // Tie from reset with both requests held: m0 at t+2, m1 at t+5, then alternating.
        @(negedge clock);
        drive(0, 1, 0, 2'd2, 10'd0, 32'd0);
        drive(1, 1, 0, 2'd0, 10'd5, 32'd0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            chk($sformatf("tie_m0_ack_c%0d", k), m0_ack, (k % 6) == 2);
            chk($sformatf("tie_m1_ack_c%0d", k), m1_ack, (k % 6) == 5);
            if (m0_ack) chk($sformatf("tie_m0_rd_c%0d", k), m0_rdata, ref_load(10'd0, 2'd2));
            if (m1_ack) chk($sformatf("tie_m1_rd_c%0d", k), m1_rdata, ref_load(10'd5, 2'd0));
            if (k == 11) begin
                drive(0, 0, 0, 2'd0, 10'd0, 32'd0);
                drive(1, 0, 0, 2'd0, 10'd0, 32'd0);
            end
        end
        last_win = 1'b1;

        for (int i = 0; i < 12; i++) do_txn(tbl[i], i);

        // Reset during the ACCESS cycle of an m0 word store drops it without an ack.
        @(negedge clock);
        drive(0, 1, 1, 2'd2, 10'd100, 32'hDEADBEEF);
        @(negedge clock);
        chk("rmid_ctrl_access", em_control, 3'd3);
        reset = 1'b1;
        drive(0, 0, 0, 2'd0, 10'd0, 32'd0);
        @(negedge clock);
        chk("rmid_busy", busy, 1'b0);
        chk("rmid_ctrl", em_control, 3'd0);
        chk("rmid_ack", m0_ack, 1'b0);
        reset = 1'b0;
        last_win = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk($sformatf("rmid_noack_%0d", k), {m1_ack, m0_ack}, 2'b00);
        end
        v = mk(0, 0, 2'd2, 10'd100, 32'h0, 3'd0, 0, ref_load(10'd100, 2'd2));
        do_txn(v, 100);

        // Randomized traffic on one or both ports.
        for (int it = 0; it < 200; it++) begin
            for (int p = 0; p < 2; p++) begin
                pend[p] = ($urandom_range(0, 3) != 0);
                r_we[p] = $urandom_range(0, 1) == 1;
                r_sz[p] = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                r_a[p]  = rand_addr();
                r_wd[p] = $urandom;
            end
            if (!pend[0] && !pend[1]) pend[0] = 1'b1;
            @(negedge clock);
            for (int p = 0; p < 2; p++)
                if (pend[p]) drive(p[0], 1'b1, r_we[p], r_sz[p], r_a[p], r_wd[p]);
            while (pend[0] || pend[1]) begin
                cyc = 0;
                do begin
                    @(negedge clock);
                    cyc++;
                end while (!(m0_ack || m1_ack) && cyc < 8);
                if (!(m0_ack || m1_ack)) begin
                    fail_now($sformatf("rand_timeout it%0d", it));
                    reset = 1'b1;
                    drive(0, 0, 0, 2'd0, 10'd0, 32'd0);
                    drive(1, 0, 0, 2'd0, 10'd0, 32'd0);
                    @(negedge clock);
                    reset = 1'b0;
                    last_win = 1'b1;
                    pend[0] = 1'b0;
                    pend[1] = 1'b0;
                end else begin
                    chk($sformatf("rand_dual_ack_it%0d", it), m0_ack && m1_ack, 1'b0);
                    winner = m1_ack;
                    exp_w  = (pend[0] && pend[1]) ? ~last_win : pend[1];
                    chk($sformatf("rand_winner_it%0d", it), winner, exp_w);
                    chk($sformatf("rand_err_it%0d", it), winner ? m1_err : m0_err,
                        ref_err(r_a[winner], r_sz[winner]));
                    chk($sformatf("rand_rdata_it%0d", it), winner ? m1_rdata : m0_rdata,
                        (r_we[winner] || ref_err(r_a[winner], r_sz[winner])) ? 32'd0
                                                                             : ref_load(r_a[winner], r_sz[winner]));
                    if (r_we[winner] && !ref_err(r_a[winner], r_sz[winner]))
                        ref_store(r_a[winner], r_sz[winner], r_wd[winner]);
                    last_win = winner;
                    pend[winner] = 1'b0;
                    drive(winner, 1'b0, 1'b0, 2'd0, 10'd0, 32'd0);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
